// File: rtl/exe_stage_mc_pkg.sv
// Shared encodings for the execute stage: command codes, forwarding selects
// and the multiply-sequencing state machine.
package exe_pkg;

   // Command encoding presented on cmd
   localparam logic [3:0] CMD_ADD = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0100;
   localparam logic [3:0] CMD_OR  = 4'b0101;
   localparam logic [3:0] CMD_NOR = 4'b0110;
   localparam logic [3:0] CMD_XOR = 4'b0111;
   localparam logic [3:0] CMD_SLL = 4'b1000;
   localparam logic [3:0] CMD_SRL = 4'b1001;
   localparam logic [3:0] CMD_SRA = 4'b1010;
   localparam logic [3:0] CMD_MUL = 4'b1100;

   // Forwarding selects; code 3 aliases the register value
   localparam logic [1:0] FWD_REG     = 2'd0;
   localparam logic [1:0] FWD_MEM     = 2'd1;
   localparam logic [1:0] FWD_WB      = 2'd2;
   localparam logic [1:0] FWD_REG_ALT = 2'd3;

   // Multiply sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      HOLD = 2'd2
   } state_e;

   function automatic logic is_mul_cmd(input logic [3:0] cmd);
      return (cmd == CMD_MUL);
   endfunction

endpackage

// File: rtl/exe_stage_mc_if.sv
// Bundle of the ID/EXE-facing inputs and the EXE/MEM-facing outputs.
interface exe_stage_mc_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic [3:0]       cmd;
   logic [WIDTH-1:0] val1;
   logic [WIDTH-1:0] val2;
   logic [WIDTH-1:0] st_value;
   logic [1:0]       val1_s;
   logic [1:0]       val2_s;
   logic [1:0]       st_s;
   logic [WIDTH-1:0] fwd_mem;
   logic [WIDTH-1:0] fwd_wb;
   logic             flush;
   logic             out_ready;
   logic             stall_out;
   logic             out_valid;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] st_value_out;

   modport slave (
      input  in_valid, cmd, val1, val2, st_value, val1_s, val2_s, st_s,
             fwd_mem, fwd_wb, flush, out_ready,
      output stall_out, out_valid, alu_result, st_value_out
   );

   modport master (
      output in_valid, cmd, val1, val2, st_value, val1_s, val2_s, st_s,
             fwd_mem, fwd_wb, flush, out_ready,
      input  stall_out, out_valid, alu_result, st_value_out
   );
endinterface

// File: rtl/exe_stage_mc_seq_multiplier.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// Only the low WIDTH bits of the product are kept.
module seq_multiplier #(parameter int WIDTH = 32) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] acc_sum_s;
   logic             done_s;

   // Next-state for one shift-add iteration, start capture or abort
   always_comb begin
      acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
      done_s    = busy_q && (cnt_q == CW'(WIDTH - 1));
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      if (abort) begin
         busy_d = 1'b0;
         cnt_d  = {CW{1'b0}};
      end else if (start) begin
         mcand_d  = a;
         mplier_d = b;
         acc_d    = {WIDTH{1'b0}};
         cnt_d    = {CW{1'b0}};
         busy_d   = 1'b1;
      end else if (busy_q) begin
         acc_d    = acc_sum_s;
         mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
         mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
         if (done_s) begin
            busy_d = 1'b0;
            cnt_d  = {CW{1'b0}};
         end else begin
            cnt_d  = cnt_q + CW'(1);
         end
      end else begin
         busy_d = 1'b0;
      end
   end

   // Operand, accumulator and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand_q  <= {WIDTH{1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         acc_q    <= {WIDTH{1'b0}};
         cnt_q    <= {CW{1'b0}};
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   // During the last iteration the product is the accumulator plus the final partial
   assign busy    = busy_q;
   assign done    = done_s;
   assign product = busy_q ? acc_sum_s : acc_q;
endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage: forwarding muxes, single-cycle ALU, iterative multiply and a
// registered EXE/MEM output with valid/ready backpressure.
module exe_stage_mc #(parameter int WIDTH = 32) (
   input logic           clk,
   input logic           rst,
   exe_stage_mc_if.slave bus
);
   import exe_pkg::*;

   localparam int SHW = $clog2(WIDTH);

   function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel,
      input logic [WIDTH-1:0] reg_v, input logic [WIDTH-1:0] mem_v,
      input logic [WIDTH-1:0] wb_v);
      case (sel)
         FWD_MEM: fwd_mux = mem_v;
         FWD_WB:  fwd_mux = wb_v;
         default: fwd_mux = reg_v;
      endcase
   endfunction

   state_e           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] alu_result_q, alu_result_d;
   logic [WIDTH-1:0] st_value_out_q, st_value_out_d;
   logic [WIDTH-1:0] st_cap_q, st_cap_d;

   logic [WIDTH-1:0] val1_fd_s, val2_fd_s, st_fd_s, alu_s, mul_product_s;
   logic [SHW-1:0]   shamt_s;
   logic             can_load_s, accept_s, mul_start_s, mul_busy_s, mul_done_s;

   // Forwarding muxes and the single-cycle ALU
   always_comb begin
      val1_fd_s = fwd_mux(bus.val1_s, bus.val1, bus.fwd_mem, bus.fwd_wb);
      val2_fd_s = fwd_mux(bus.val2_s, bus.val2, bus.fwd_mem, bus.fwd_wb);
      st_fd_s   = fwd_mux(bus.st_s, bus.st_value, bus.fwd_mem, bus.fwd_wb);
      shamt_s   = val2_fd_s[SHW-1:0];
      alu_s     = {WIDTH{1'b0}};
      case (bus.cmd)
         CMD_ADD: alu_s = val1_fd_s + val2_fd_s;
         CMD_SUB: alu_s = val1_fd_s - val2_fd_s;
         CMD_AND: alu_s = val1_fd_s & val2_fd_s;
         CMD_OR:  alu_s = val1_fd_s | val2_fd_s;
         CMD_NOR: alu_s = ~(val1_fd_s | val2_fd_s);
         CMD_XOR: alu_s = val1_fd_s ^ val2_fd_s;
         CMD_SLL: alu_s = val1_fd_s << shamt_s;
         CMD_SRL: alu_s = val1_fd_s >> shamt_s;
         CMD_SRA: alu_s = $unsigned($signed(val1_fd_s) >>> shamt_s);
         default: alu_s = {WIDTH{1'b0}};
      endcase
   end

   assign can_load_s = !out_valid_q || bus.out_ready;
   assign accept_s   = bus.in_valid && (state_q == IDLE) && can_load_s && !bus.flush;

   seq_multiplier #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start_s),
      .abort   (bus.flush),
      .a       (val1_fd_s),
      .b       (val2_fd_s),
      .busy    (mul_busy_s),
      .done    (mul_done_s),
      .product (mul_product_s)
   );

   // Sequencing of accepts, multiply completion and the output register
   always_comb begin
      state_d        = state_q;
      out_valid_d    = out_valid_q;
      alu_result_d   = alu_result_q;
      st_value_out_d = st_value_out_q;
      st_cap_d       = st_cap_q;
      mul_start_s    = 1'b0;
      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      if (bus.flush) begin
         out_valid_d = 1'b0;
         state_d     = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_s && is_mul_cmd(bus.cmd)) begin
                  mul_start_s = 1'b1;
                  st_cap_d    = st_fd_s;
                  state_d     = MUL;
               end else if (accept_s) begin
                  alu_result_d   = alu_s;
                  st_value_out_d = st_fd_s;
                  out_valid_d    = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            MUL: begin
               if (mul_done_s && can_load_s) begin
                  alu_result_d   = mul_product_s;
                  st_value_out_d = st_cap_q;
                  out_valid_d    = 1'b1;
                  state_d        = IDLE;
               end else if (mul_done_s) begin
                  state_d = HOLD;
               end else if (!mul_busy_s) begin
                  // multiplier lost its job: recover rather than hang
                  state_d = IDLE;
               end else begin
                  state_d = MUL;
               end
            end
            HOLD: begin
               if (can_load_s) begin
                  alu_result_d   = mul_product_s;
                  st_value_out_d = st_cap_q;
                  out_valid_d    = 1'b1;
                  state_d        = IDLE;
               end else begin
                  state_d = HOLD;
               end
            end
            default: begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // Pipeline state and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         out_valid_q    <= 1'b0;
         alu_result_q   <= {WIDTH{1'b0}};
         st_value_out_q <= {WIDTH{1'b0}};
         st_cap_q       <= {WIDTH{1'b0}};
      end else begin
         state_q        <= state_d;
         out_valid_q    <= out_valid_d;
         alu_result_q   <= alu_result_d;
         st_value_out_q <= st_value_out_d;
         st_cap_q       <= st_cap_d;
      end
   end

   assign bus.stall_out    = (state_q != IDLE) || (bus.in_valid && !can_load_s);
   assign bus.out_valid    = out_valid_q;
   assign bus.alu_result   = alu_result_q;
   assign bus.st_value_out = st_value_out_q;
endmodule
